// File: rtl/ens_lut_pkg.sv
// rtl/ens_lut_pkg.sv - shared widths, state type and address packing for the ensemble LUT layer
package ens_lut_pkg;

   localparam int BW     = 2;
   localparam int FANIN  = 3;
   localparam int ADDR_W = FANIN * BW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Slot 0 lands in the most significant bits of the table address.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic [FANIN-1:0][BW-1:0] acts);
      logic [ADDR_W-1:0] a;
      a = '0;
      for (int s = 0; s < FANIN; s++) begin
         a[ADDR_W-1-s*BW -: BW] = acts[s];
      end
      return a;
   endfunction

endpackage

// File: rtl/ens_lut_table_ram.sv
// rtl/ens_lut_table_ram.sv - per-neuron truth tables in one distributed RAM, sync write, async read
module ens_lut_table_ram
   import ens_lut_pkg::*;
#(
   parameter int NUM_NEURONS = 64,
   localparam int NW = $clog2(NUM_NEURONS)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [NW-1:0]     wr_neuron_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [BW-1:0]     wr_data_i,
   input  logic [NW-1:0]     rd_neuron_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [BW-1:0]     rd_data_o
);

   localparam int DEPTH = NUM_NEURONS * (2 ** ADDR_W);

   (* ram_style = "distributed", rom_style = "distributed" *)
   logic [BW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[{wr_neuron_i, wr_addr_i}] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[{rd_neuron_i, rd_addr_i}];

endmodule

// File: rtl/ens_layer_lut_scheduler.sv
// rtl/ens_layer_lut_scheduler.sv - evaluates one ensemble LUT layer, one neuron per cycle
module ens_layer_lut_scheduler
   import ens_lut_pkg::*;
#(
   parameter int NUM_IN      = 16,
   parameter int NUM_NEURONS = 64,
   localparam int NW = $clog2(NUM_NEURONS),
   localparam int SW = $clog2(FANIN),
   localparam int IW = $clog2(NUM_IN)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_IN*BW-1:0]      in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_NEURONS*BW-1:0] out_data,
   input  logic                      tt_we,
   input  logic [NW-1:0]             tt_neuron,
   input  logic [ADDR_W-1:0]         tt_addr,
   input  logic [BW-1:0]             tt_data,
   input  logic                      conn_we,
   input  logic [NW-1:0]             conn_neuron,
   input  logic [SW-1:0]             conn_slot,
   input  logic [IW-1:0]             conn_idx,
   output logic                      busy
);

   state_e                     state_q, state_d;
   logic [NW-1:0]              cnt_q, cnt_d;
   logic [NUM_IN*BW-1:0]       x_q;
   logic [NUM_NEURONS*BW-1:0]  out_q;
   logic [IW-1:0]              conn_q [NUM_NEURONS][FANIN];

   logic                       idle, accept, tt_ok, conn_ok;
   logic [FANIN-1:0][BW-1:0]   gathered;
   logic [ADDR_W-1:0]          rd_addr;
   logic [BW-1:0]              rd_data;

   assign idle      = (state_q == IDLE);
   assign in_ready  = idle & ~(tt_we | conn_we);
   assign accept    = in_valid & in_ready;
   assign busy      = ~idle;
   assign out_valid = (state_q == DONE);
   assign out_data  = out_q;

   // Config is only honoured in IDLE; out-of-range targets are dropped.
   assign tt_ok   = idle & tt_we & (32'(tt_neuron) < NUM_NEURONS);
   assign conn_ok = idle & conn_we & (32'(conn_neuron) < NUM_NEURONS)
                  & (32'(conn_slot) < FANIN) & (32'(conn_idx) < NUM_IN);

   always_comb begin
      gathered = '0;
      for (int s = 0; s < FANIN; s++) begin
         gathered[s] = x_q[32'(conn_q[cnt_q][s])*BW +: BW];
      end
      rd_addr = pack_addr(gathered);
   end

   ens_lut_table_ram #(
      .NUM_NEURONS (NUM_NEURONS)
   ) u_table (
      .clk         (clk),
      .we_i        (tt_ok),
      .wr_neuron_i (tt_neuron),
      .wr_addr_i   (tt_addr),
      .wr_data_i   (tt_data),
      .rd_neuron_i (cnt_q),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (cnt_q == NW'(NUM_NEURONS-1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == RUN) begin
            out_q[32'(cnt_q)*BW +: BW] <= rd_data;
         end
      end
   end

   // Input vector and connectivity table are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_q <= in_data;
      end
      if (conn_ok) begin
         conn_q[conn_neuron][conn_slot] <= conn_idx;
      end
   end

endmodule
